pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RV32I pipeline. Drives the enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, inserts bubbles into ID/EX and flushes IF/ID. Handles three cases:
- load-use stalls;
- EX-stage redirects (taken branch or jump);
- multi-cycle data-memory waits, with a timeout that freezes the core in an error state.

It also keeps saturating stall and flush counters for debug.

---
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RV32I pipeline.
// Decides the stage enables, the ID/EX bubble and the IF/ID flush in the same
// cycle, tracks data-memory waits with a timeout that locks the core in ERR,
// and keeps saturating stall/flush counters for debug.
module pipeline_ctrl #(
    parameter logic [6:0] LOAD_OP     = 7'b0000011,
    parameter int         MEM_TIMEOUT = 64,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [6:0]       ex_op,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             ena_pc,
    output logic             ena_ifid,
    output logic             ena_idex,
    output logic             ena_exmem,
    output logic             ena_memwb,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MEMWAIT = 2'd1;
    localparam logic [1:0] S_ERR     = 2'd2;

    // Wide enough to hold MEM_TIMEOUT-1, the last count before the trip.
    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]        state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic freeze;
    logic load_use;
    logic in_err;
    logic stall_evt;
    logic flush_evt;

    assign freeze   = mem_req & ~mem_ready;
    assign load_use = (ex_op == LOAD_OP) && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Encoding 3 is unreachable; treating it as ERR keeps the core parked if it ever appears.
    assign in_err = state_q[1];

    // A redirect hides a coincident load-use because its consumer is flushed anyway.
    assign stall_evt = ~in_err & (freeze | (load_use & ~ex_redirect));
    assign flush_evt = ~in_err & ~freeze & ex_redirect;

    assign state     = state_q;
    assign mem_err   = (state_q == S_ERR);
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

    // Same-cycle control decision, priority ERR > freeze > redirect > load-use > normal.
    always_comb begin
        ena_pc      = 1'b0;
        ena_ifid    = 1'b0;
        ena_idex    = 1'b0;
        ena_exmem   = 1'b0;
        ena_memwb   = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        if (rst || in_err || freeze) begin
            ena_pc = 1'b0;
        end else if (ex_redirect) begin
            ena_pc      = 1'b1;
            ena_ifid    = 1'b1;
            ena_idex    = 1'b1;
            ena_exmem   = 1'b1;
            ena_memwb   = 1'b1;
            bubble_idex = 1'b1;
            flush_ifid  = 1'b1;
        end else if (load_use) begin
            ena_idex    = 1'b1;
            ena_exmem   = 1'b1;
            ena_memwb   = 1'b1;
            bubble_idex = 1'b1;
        end else begin
            ena_pc    = 1'b1;
            ena_ifid  = 1'b1;
            ena_idex  = 1'b1;
            ena_exmem = 1'b1;
            ena_memwb = 1'b1;
        end
    end

    // Memory-wait tracker: counts consecutive freeze cycles and trips ERR on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (freeze) begin
                        state_q  <= S_MEMWAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEMWAIT: begin
                    if (!freeze) begin
                        state_q  <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ERR;
                end
            endcase
        end
    end

    // Saturating debug counters for stall/freeze cycles and taken redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_evt && (flush_q != CNT_MAX)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed, table-driven checks of the hazard controller,
// plus hand-written sequences for stalls, freezes, timeout and saturation.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [6:0] ex_op = '0;
    logic [4:0] ex_rd = '0;
    logic       ex_redirect = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;

    logic       ena_pc, ena_ifid, ena_idex, ena_exmem, ena_memwb, bubble_idex, flush_ifid;
    logic [1:0] state;
    logic       mem_err;
    logic [7:0] stall_cnt, flush_cnt;

    logic       s_ena_pc, s_ena_ifid, s_ena_idex, s_ena_exmem, s_ena_memwb, s_bubble, s_flush;
    logic [1:0] s_state;
    logic       s_mem_err;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    logic [6:0] outs;
    assign outs = {ena_pc, ena_ifid, ena_idex, ena_exmem, ena_memwb, bubble_idex, flush_ifid};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .ena_pc(ena_pc), .ena_ifid(ena_ifid), .ena_idex(ena_idex),
        .ena_exmem(ena_exmem), .ena_memwb(ena_memwb),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
        .state(state), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .ena_pc(s_ena_pc), .ena_ifid(s_ena_ifid), .ena_idex(s_ena_idex),
        .ena_exmem(s_ena_exmem), .ena_memwb(s_ena_memwb),
        .bubble_idex(s_bubble), .flush_ifid(s_flush),
        .state(s_state), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [6:0] op;
        logic [4:0] rd;
        logic       redir;
        logic       mreq;
        logic       mrdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mkVec(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic use1, input logic use2, input logic [6:0] op,
                                   input logic [4:0] rd, input logic redir, input logic mreq,
                                   input logic mrdy, input logic [6:0] exp);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.op = op; v.rd = rd; v.redir = redir; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
        return v;
    endfunction

    // Drives one set of pipeline inputs.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2, input logic [6:0] op,
                                 input logic [4:0] rd, input logic redir,
                                 input logic mreq, input logic mrdy);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = use1; id_use_rs2 = use2;
        ex_op = op; ex_rd = rd; ex_redirect = redir; mem_req = mreq; mem_ready = mrdy;
    endtask

    task automatic clearInputs();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next cycle; checks happen 1 time unit after the falling edge.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset_outs", 32'(outs), 32'h0);
        checkOutput("reset_state", 32'(state), 32'h0);
        checkOutput("reset_cnts", {stall_cnt, flush_cnt}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [6:0] NOP = 7'b0010011;

    initial begin
        vecs[0]  = mkVec("normal",        5'd1, 5'd2, 1'b1, 1'b1, ALU, 5'd3, 1'b0, 1'b0, 1'b0, 7'b1111100);
        vecs[1]  = mkVec("lu_rs1",        5'd5, 5'd0, 1'b1, 1'b0, LD,  5'd5, 1'b0, 1'b0, 1'b0, 7'b0011110);
        vecs[2]  = mkVec("lu_rs2",        5'd1, 5'd7, 1'b1, 1'b1, LD,  5'd7, 1'b0, 1'b0, 1'b0, 7'b0011110);
        vecs[3]  = mkVec("load_rd0",      5'd0, 5'd0, 1'b1, 1'b1, LD,  5'd0, 1'b0, 1'b0, 1'b0, 7'b1111100);
        vecs[4]  = mkVec("nonload_match", 5'd5, 5'd0, 1'b1, 1'b0, ALU, 5'd5, 1'b0, 1'b0, 1'b0, 7'b1111100);
        vecs[5]  = mkVec("lu_unused_rs",  5'd5, 5'd5, 1'b0, 1'b0, LD,  5'd5, 1'b0, 1'b0, 1'b0, 7'b1111100);
        vecs[6]  = mkVec("redir_and_lu",  5'd5, 5'd0, 1'b1, 1'b0, LD,  5'd5, 1'b1, 1'b0, 1'b0, 7'b1111111);
        vecs[7]  = mkVec("freeze",        5'd5, 5'd0, 1'b1, 1'b0, LD,  5'd5, 1'b0, 1'b1, 1'b0, 7'b0000000);
        vecs[8]  = mkVec("mem_ready",     5'd1, 5'd2, 1'b1, 1'b1, ALU, 5'd3, 1'b0, 1'b1, 1'b1, 7'b1111100);
        vecs[9]  = mkVec("freeze_redir",  5'd1, 5'd2, 1'b1, 1'b1, ALU, 5'd3, 1'b1, 1'b1, 1'b0, 7'b0000000);
        vecs[10] = mkVec("normal_after",  5'd1, 5'd2, 1'b1, 1'b1, ALU, 5'd3, 1'b0, 1'b0, 1'b1, 7'b1111100);

        // Table of single-cycle control decisions.
        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].op,
                          vecs[i].rd, vecs[i].redir, vecs[i].mreq, vecs[i].mrdy);
            #1;
            checkOutput(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
            nextCycle();
        end

        // Load-use inserts exactly one bubble, then the bubble clears the hazard.
        doReset();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, LD, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_seq_stall", 32'(outs), 32'h1E);
        nextCycle();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_seq_resume", 32'(outs), 32'h7C);
        checkOutput("lu_seq_stall_cnt", 32'(stall_cnt), 32'd1);

        // Redirect with a coincident load-use counts as a flush only.
        doReset();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, LD, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("rlu_outs", 32'(outs), 32'h7F);
        nextCycle();
        clearInputs();
        #1;
        checkOutput("rlu_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("rlu_stall_cnt", 32'(stall_cnt), 32'd0);

        // Freeze for 3 cycles holding a redirect, which applies once memory is ready.
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, ALU, 5'd1, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            #1;
            checkOutput($sformatf("frz_outs_c%0d", c), 32'(outs), 32'h0);
            checkOutput($sformatf("frz_state_c%0d", c), 32'(state), (c == 1) ? 32'd0 : 32'd1);
            nextCycle();
        end
        mem_ready = 1'b1;
        #1;
        checkOutput("frz_release_outs", 32'(outs), 32'h7F);
        checkOutput("frz_release_state", 32'(state), 32'd1);
        nextCycle();
        clearInputs();
        #1;
        checkOutput("frz_back_run", 32'(state), 32'd0);
        checkOutput("frz_stall_cnt", 32'(stall_cnt), 32'd3);
        checkOutput("frz_flush_cnt", 32'(flush_cnt), 32'd1);

        // MEM_TIMEOUT-1 freeze cycles are tolerated.
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, ALU, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) nextCycle();
        mem_ready = 1'b1;
        nextCycle();
        clearInputs();
        #1;
        checkOutput("to3_state", 32'(state), 32'd0);
        checkOutput("to3_mem_err", 32'(mem_err), 32'd0);
        checkOutput("to3_outs", 32'(outs), 32'h7C);

        // MEM_TIMEOUT freeze cycles trip ERR, which only reset can leave.
        doReset();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, ALU, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (4) nextCycle();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, LD, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("to4_state", 32'(state), 32'd2);
        checkOutput("to4_mem_err", 32'(mem_err), 32'd1);
        checkOutput("to4_outs", 32'(outs), 32'h0);
        checkOutput("to4_stall_cnt", 32'(stall_cnt), 32'd4);
        nextCycle();
        #1;
        checkOutput("err_sticky_state", 32'(state), 32'd2);
        checkOutput("err_no_count", {stall_cnt, flush_cnt}, {8'd4, 8'd0});
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_state", 32'(state), 32'd0);
        checkOutput("async_rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("async_rst_outs", 32'(outs), 32'h0);
        checkOutput("async_rst_cnts", {stall_cnt, flush_cnt}, 32'h0);

        // Held load-use for 5 cycles: the 2-bit counter saturates at 3.
        doReset();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, LD, 5'd5, 1'b0, 1'b0, 1'b0);
        repeat (5) nextCycle();
        #1;
        checkOutput("sat_stall_cnt", 32'(s_stall_cnt), 32'd3);
        checkOutput("wide_stall_cnt", 32'(stall_cnt), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
